// File: rtl/riscv_soft_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : riscv_soft_mem_arbiter
// Description : Shares one memory port between the I-cache and D-cache channels,
//               one outstanding request, D priority with I starvation guard.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_soft_mem_arbiter #(
  parameter int XPR_LEN      = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_cache_req_valid,
  output logic               i_cache_req_ready,
  input  logic [XPR_LEN-1:0] i_cache_req_addr,
  output logic               i_cache_resp_valid,
  output logic [XPR_LEN-1:0] i_cache_resp_data,
  input  logic               d_cache_req_valid,
  output logic               d_cache_req_ready,
  input  logic [1:0]         d_cache_req_op,
  input  logic [2:0]         d_cache_req_op_type,
  input  logic [XPR_LEN-1:0] d_cache_req_addr,
  input  logic [XPR_LEN-1:0] d_cache_req_data,
  output logic               d_cache_resp_valid,
  output logic [XPR_LEN-1:0] d_cache_resp_data,
  output logic               mem_req_valid,
  input  logic               mem_req_ready,
  output logic [1:0]         mem_req_op,
  output logic [2:0]         mem_req_op_type,
  output logic [XPR_LEN-1:0] mem_req_addr,
  output logic [XPR_LEN-1:0] mem_req_data,
  input  logic               mem_resp_valid,
  input  logic [XPR_LEN-1:0] mem_resp_data
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] c_STARVE_MAX = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t             r_state;
  logic [CW-1:0]      r_starve;
  logic               r_owner_d;
  logic               r_mem_req_valid;
  logic [1:0]         r_op;
  logic [2:0]         r_op_type;
  logic [XPR_LEN-1:0] r_addr;
  logic [XPR_LEN-1:0] r_data;
  logic               r_i_resp_valid;
  logic               r_d_resp_valid;
  logic [XPR_LEN-1:0] r_i_resp_data;
  logic [XPR_LEN-1:0] r_d_resp_data;

  logic w_idle;
  logic w_starved;
  logic w_grant_d;
  logic w_grant_i;

  // Readys are gated by reset so nothing looks accepted while reset is held.
  assign w_idle    = reset && (r_state == S_IDLE);
  assign w_starved = i_cache_req_valid && (r_starve == c_STARVE_MAX);
  assign w_grant_d = w_idle && d_cache_req_valid && !w_starved;
  assign w_grant_i = w_idle && i_cache_req_valid && !(d_cache_req_valid && !w_starved);

  assign i_cache_req_ready  = w_grant_i;
  assign d_cache_req_ready  = w_grant_d;
  assign mem_req_valid      = r_mem_req_valid;
  assign mem_req_op         = r_op;
  assign mem_req_op_type    = r_op_type;
  assign mem_req_addr       = r_addr;
  assign mem_req_data       = r_data;
  assign i_cache_resp_valid = r_i_resp_valid;
  assign i_cache_resp_data  = r_i_resp_data;
  assign d_cache_resp_valid = r_d_resp_valid;
  assign d_cache_resp_data  = r_d_resp_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state         <= S_IDLE;
      r_starve        <= '0;
      r_owner_d       <= 1'b0;
      r_mem_req_valid <= 1'b0;
      r_op            <= '0;
      r_op_type       <= '0;
      r_addr          <= '0;
      r_data          <= '0;
      r_i_resp_valid  <= 1'b0;
      r_d_resp_valid  <= 1'b0;
      r_i_resp_data   <= '0;
      r_d_resp_data   <= '0;
    end else begin
      r_i_resp_valid <= 1'b0;
      r_d_resp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant_d) begin
            r_op            <= d_cache_req_op;
            r_op_type       <= d_cache_req_op_type;
            r_addr          <= d_cache_req_addr;
            r_data          <= d_cache_req_data;
            r_owner_d       <= 1'b1;
            r_mem_req_valid <= 1'b1;
            r_state         <= S_ISSUE;
            if (!i_cache_req_valid)
              r_starve <= '0;
            else if (r_starve != c_STARVE_MAX)
              r_starve <= r_starve + CW'(1);
          end else if (w_grant_i) begin
            r_op            <= 2'b00;
            r_op_type       <= 3'b010;
            r_addr          <= i_cache_req_addr;
            r_data          <= '0;
            r_owner_d       <= 1'b0;
            r_mem_req_valid <= 1'b1;
            r_state         <= S_ISSUE;
            r_starve        <= '0;
          end else if (!i_cache_req_valid) begin
            r_starve <= '0;
          end
        end
        S_ISSUE: begin
          if (mem_req_ready) begin
            r_mem_req_valid <= 1'b0;
            r_state         <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_resp_valid) begin
            if (r_owner_d) begin
              r_d_resp_valid <= 1'b1;
              r_d_resp_data  <= mem_resp_data;
            end else begin
              r_i_resp_valid <= 1'b1;
              r_i_resp_data  <= mem_resp_data;
            end
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_riscv_soft_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_riscv_soft_mem_arbiter
// Description : Directed self-checking bench for riscv_soft_mem_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_riscv_soft_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        i_cache_req_valid = 1'b0;
  logic        i_cache_req_ready;
  logic [31:0] i_cache_req_addr = '0;
  logic        i_cache_resp_valid;
  logic [31:0] i_cache_resp_data;
  logic        d_cache_req_valid = 1'b0;
  logic        d_cache_req_ready;
  logic [1:0]  d_cache_req_op = '0;
  logic [2:0]  d_cache_req_op_type = '0;
  logic [31:0] d_cache_req_addr = '0;
  logic [31:0] d_cache_req_data = '0;
  logic        d_cache_resp_valid;
  logic [31:0] d_cache_resp_data;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [1:0]  mem_req_op;
  logic [2:0]  mem_req_op_type;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_data;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_data = '0;

  int n_cmp = 0;
  int n_err = 0;
  logic        auto_mem = 1'b0;
  logic        pend = 1'b0;
  logic [31:0] rdata = 32'h1000_0000;

  riscv_soft_mem_arbiter #(.XPR_LEN(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .i_cache_req_valid(i_cache_req_valid), .i_cache_req_ready(i_cache_req_ready),
    .i_cache_req_addr(i_cache_req_addr),
    .i_cache_resp_valid(i_cache_resp_valid), .i_cache_resp_data(i_cache_resp_data),
    .d_cache_req_valid(d_cache_req_valid), .d_cache_req_ready(d_cache_req_ready),
    .d_cache_req_op(d_cache_req_op), .d_cache_req_op_type(d_cache_req_op_type),
    .d_cache_req_addr(d_cache_req_addr), .d_cache_req_data(d_cache_req_data),
    .d_cache_resp_valid(d_cache_resp_valid), .d_cache_resp_data(d_cache_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_op(mem_req_op), .mem_req_op_type(mem_req_op_type),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
  );

  always #5 clk = ~clk;

  // Auto memory: accepts immediately, answers in the following cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (auto_mem) begin
        if (pend) begin
          mem_resp_valid = 1'b1;
          mem_resp_data  = rdata;
          rdata          = rdata + 32'd1;
          pend           = 1'b0;
        end else begin
          mem_resp_valid = 1'b0;
        end
        if (mem_req_valid && mem_req_ready) pend = 1'b1;
      end
    end
  end

  task automatic test_reset();
    reset = 1'b0;
    i_cache_req_valid = 1'b1;
    d_cache_req_valid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if ({i_cache_req_ready, d_cache_req_ready, mem_req_valid, i_cache_resp_valid, d_cache_resp_valid} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b expected 00000",
        {i_cache_req_ready, d_cache_req_ready, mem_req_valid, i_cache_resp_valid, d_cache_resp_valid});
    end
    n_cmp++;
    if ({mem_req_op, mem_req_op_type, mem_req_addr, mem_req_data, i_cache_resp_data, d_cache_resp_data} !== '0) begin
      n_err++;
      $display("FAIL reset_data: addr=%h data=%h iresp=%h dresp=%h expected all 0",
        mem_req_addr, mem_req_data, i_cache_resp_data, d_cache_resp_data);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({d_cache_req_ready, i_cache_req_ready} !== 2'b10) begin
      n_err++;
      $display("FAIL reset_release_grant: d/i ready got %b expected 10", {d_cache_req_ready, i_cache_req_ready});
    end
    i_cache_req_valid = 1'b0;
    d_cache_req_valid = 1'b0;
  endtask

  task automatic test_single_fetch();
    @(negedge clk);
    i_cache_req_valid = 1'b1;
    i_cache_req_addr  = 32'h100;
    #1;
    n_cmp++;
    if (i_cache_req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL fetch_ready: got %b expected 1", i_cache_req_ready);
    end
    @(negedge clk);
    i_cache_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    #1;
    n_cmp++;
    if ({mem_req_valid, mem_req_op, mem_req_op_type, mem_req_addr, mem_req_data} !== {1'b1, 2'b00, 3'b010, 32'h100, 32'h0}) begin
      n_err++;
      $display("FAIL fetch_issue: v=%b op=%b opt=%b addr=%h data=%h expected 1 00 010 00000100 00000000",
        mem_req_valid, mem_req_op, mem_req_op_type, mem_req_addr, mem_req_data);
    end
    @(negedge clk);
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'hDEADBEEF;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    #1;
    n_cmp++;
    if ({i_cache_resp_valid, d_cache_resp_valid, i_cache_resp_data} !== {1'b1, 1'b0, 32'hDEADBEEF}) begin
      n_err++;
      $display("FAIL fetch_resp: iv=%b dv=%b data=%h expected 1 0 deadbeef",
        i_cache_resp_valid, d_cache_resp_valid, i_cache_resp_data);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if ({i_cache_resp_valid, i_cache_resp_data} !== {1'b0, 32'hDEADBEEF}) begin
      n_err++;
      $display("FAIL fetch_pulse_end: iv=%b data=%h expected 0 deadbeef", i_cache_resp_valid, i_cache_resp_data);
    end
  endtask

  task automatic test_store_backpressure();
    @(negedge clk);
    d_cache_req_valid   = 1'b1;
    d_cache_req_op      = 2'b01;
    d_cache_req_op_type = 3'b010;
    d_cache_req_addr    = 32'h20;
    d_cache_req_data    = 32'h55;
    #1;
    n_cmp++;
    if (d_cache_req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL store_ready: got %b expected 1", d_cache_req_ready);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      d_cache_req_valid = 1'b0;
      d_cache_req_addr  = 32'hFFFF_FFFF;
      mem_req_ready     = (c == 3);
      #1;
      n_cmp++;
      if ({mem_req_valid, mem_req_op, mem_req_op_type, mem_req_addr, mem_req_data} !== {1'b1, 2'b01, 3'b010, 32'h20, 32'h55}) begin
        n_err++;
        $display("FAIL store_hold[%0d]: v=%b op=%b addr=%h data=%h expected 1 01 00000020 00000055",
          c, mem_req_valid, mem_req_op, mem_req_addr, mem_req_data);
      end
    end
    @(negedge clk);
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h0;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    #1;
    n_cmp++;
    if ({d_cache_resp_valid, i_cache_resp_valid, i_cache_resp_data} !== {1'b1, 1'b0, 32'hDEADBEEF}) begin
      n_err++;
      $display("FAIL store_ack: dv=%b iv=%b idata=%h expected 1 0 deadbeef",
        d_cache_resp_valid, i_cache_resp_valid, i_cache_resp_data);
    end
  endtask

  task automatic test_grant_order();
    logic exp_d [10];
    logic got_d [10];
    int   got = 0;
    exp_d = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    @(negedge clk);
    reset = 1'b0;
    i_cache_req_valid = 1'b1;
    d_cache_req_valid = 1'b1;
    d_cache_req_op    = 2'b00;
    mem_req_ready     = 1'b1;
    pend              = 1'b0;
    auto_mem          = 1'b1;
    #1;
    reset = 1'b1;
    for (int cyc = 0; cyc < 80 && got < 10; cyc++) begin
      #1;
      if (i_cache_req_ready && d_cache_req_ready) begin
        n_cmp++;
        n_err++;
        $display("FAIL grant_exclusive: both readys high at cycle %0d expected one", cyc);
      end else if (i_cache_req_ready || d_cache_req_ready) begin
        got_d[got] = d_cache_req_ready;
        got++;
      end
      @(negedge clk);
    end
    n_cmp++;
    if (got != 10) begin
      n_err++;
      $display("FAIL grant_budget: got %0d grants expected 10", got);
    end
    for (int k = 0; k < got; k++) begin
      n_cmp++;
      if (got_d[k] !== exp_d[k]) begin
        n_err++;
        $display("FAIL grant_order[%0d]: got %s expected %s", k, got_d[k] ? "D" : "I", exp_d[k] ? "D" : "I");
      end
    end
    i_cache_req_valid = 1'b0;
    d_cache_req_valid = 1'b0;
    repeat (5) @(negedge clk);
    auto_mem       = 1'b0;
    mem_resp_valid = 1'b0;
    mem_req_ready  = 1'b0;
  endtask

  task automatic test_async_reset_wait();
    @(negedge clk);
    d_cache_req_valid = 1'b1;
    d_cache_req_op    = 2'b00;
    d_cache_req_addr  = 32'h40;
    @(negedge clk);
    d_cache_req_valid = 1'b0;
    mem_req_ready     = 1'b1;
    @(negedge clk);
    mem_req_ready     = 1'b0;
    i_cache_req_valid = 1'b1;
    d_cache_req_valid = 1'b1;
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({mem_req_valid, i_cache_req_ready, d_cache_req_ready, mem_req_addr, d_cache_resp_data} !== '0) begin
      n_err++;
      $display("FAIL async_reset: v=%b ir=%b dr=%b addr=%h dresp=%h expected all 0",
        mem_req_valid, i_cache_req_ready, d_cache_req_ready, mem_req_addr, d_cache_resp_data);
    end
    i_cache_req_valid = 1'b0;
    d_cache_req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h1234;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    #1;
    n_cmp++;
    if ({d_cache_resp_valid, i_cache_resp_valid, d_cache_resp_data} !== {2'b00, 32'h0}) begin
      n_err++;
      $display("FAIL late_resp: dv=%b iv=%b dresp=%h expected 0 0 00000000",
        d_cache_resp_valid, i_cache_resp_valid, d_cache_resp_data);
    end
  endtask

  task automatic test_stray_resp();
    @(negedge clk);
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h0BAD;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    i_cache_req_valid = 1'b1;
    i_cache_req_addr  = 32'h200;
    #1;
    n_cmp++;
    if ({i_cache_resp_valid, d_cache_resp_valid, mem_req_valid, i_cache_req_ready} !== 4'b0001) begin
      n_err++;
      $display("FAIL stray_resp: iv=%b dv=%b mv=%b iready=%b expected 0 0 0 1",
        i_cache_resp_valid, d_cache_resp_valid, mem_req_valid, i_cache_req_ready);
    end
    i_cache_req_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_store_backpressure();
    test_grant_order();
    test_async_reset_wait();
    test_stray_resp();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
